// File: rtl/tile_spawner_if.sv
// rtl/tile_spawner_if.sv - spawn request handshake between tile_spawner and the renderer
interface tile_spawner_if;
    logic       spawn_valid;
    logic       spawn_ready;
    logic [2:0] spawn_lane;
    logic [7:0] spawn_seq;

    modport master (output spawn_valid, output spawn_lane, output spawn_seq, input spawn_ready);
    modport slave  (input spawn_valid, input spawn_lane, input spawn_seq, output spawn_ready);
endinterface

// File: rtl/tile_spawner.sv
// rtl/tile_spawner.sv - paced random lane spawner with repeat limit and spawn FIFO (optional SPAWN_SPEEDUP_EN)
module tile_spawner #(
    parameter int NUM_LANES    = 4,
    parameter int SPAWN_PERIOD = 8,
    parameter int MAX_REPEAT   = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int MIN_PERIOD   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          tick,
    input  logic [2:0]                    random,
    tile_spawner_if.master                spawn,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = $clog2(MAX_REPEAT + 1);

    typedef enum logic [1:0] {IDLE, COUNT, DRAW} state_t;

    state_t         state, state_nxt;
    logic [7:0]     tick_cnt, tick_cnt_nxt;
    logic [7:0]     period;
    logic           draw;

    logic [2:0]     last_lane;
    logic [RW-1:0]  run_len, run_nxt;
    logic [2:0]     r_val, cand, lane;

    logic [2:0]     lane_mem [FIFO_DEPTH];
    logic [7:0]     seq_mem  [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [LW-1:0]  level;
    logic [7:0]     seq_cnt;
    logic           full, pop, push_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        case (state)
            IDLE: begin
                tick_cnt_nxt = '0;
                if (enable) state_nxt = COUNT;
            end
            COUNT: begin
                if (!enable) begin
                    state_nxt    = IDLE;
                    tick_cnt_nxt = '0;
                end else if (tick) begin
                    if (tick_cnt == period - 8'd1) begin
                        tick_cnt_nxt = '0;
                        state_nxt    = DRAW;
                    end else begin
                        tick_cnt_nxt = tick_cnt + 8'd1;
                    end
                end
            end
            DRAW:    state_nxt = enable ? COUNT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        draw = (state == DRAW);
    end

    // A zero from the random source is treated as 1 so every draw lands on a lane.
    always_comb begin
        r_val = (random == 3'd0) ? 3'd1 : random;
        cand  = 3'((32'(r_val) - 32'd1) % NUM_LANES);
        lane  = cand;
        if (cand == last_lane && run_len == RW'(MAX_REPEAT)) begin
            lane    = 3'((32'(cand) + 32'd1) % NUM_LANES);
            run_nxt = RW'(1);
        end else if (cand == last_lane) begin
            run_nxt = run_len + RW'(1);
        end else begin
            run_nxt = RW'(1);
        end
    end

`ifdef SPAWN_SPEEDUP_EN
    logic [3:0] push_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period   <= 8'(SPAWN_PERIOD);
            push_cnt <= '0;
        end else if (push_ok) begin
            push_cnt <= push_cnt + 4'd1;
            if (push_cnt == 4'd15 && period > 8'(MIN_PERIOD))
                period <= period - 8'd1;
        end
    end
`else
    assign period = 8'(SPAWN_PERIOD);
`endif

    assign full    = (level == LW'(FIFO_DEPTH));
    assign pop     = spawn.spawn_valid && spawn.spawn_ready;
    // When full, a simultaneous pop frees the slot the push writes into.
    assign push_ok = draw && (!full || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            seq_cnt   <= '0;
            overflow  <= 1'b0;
            last_lane <= '0;
            run_len   <= '0;
        end else begin
            if (draw) begin
                last_lane <= lane;
                run_len   <= run_nxt;
                if (!push_ok) overflow <= 1'b1;
            end
            if (push_ok) begin
                wr_ptr  <= wr_ptr + 1'b1;
                seq_cnt <= seq_cnt + 8'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            lane_mem[wr_ptr] <= lane;
            seq_mem[wr_ptr]  <= seq_cnt;
        end
    end

    assign spawn.spawn_valid = (level != '0);
    assign spawn.spawn_lane  = spawn.spawn_valid ? lane_mem[rd_ptr] : 3'd0;
    assign spawn.spawn_seq   = spawn.spawn_valid ? seq_mem[rd_ptr]  : 8'd0;
    assign fifo_level        = level;
endmodule
